score_display: RTL
==================

// Module: score_display
// PURPOSE
//  Downstream display stage for the game top level. Takes the free-running game
//  score and keeps a high-score register. Converts the selected value (score or
//  high) to BCD with a sequential double-dabble FSM. Drives the 4-digit
//  multiplexed 7-segment display (Nexys-style, active-low segments/anodes).
// PARAMETERS
//  REFRESH_BITS  17  width of scan counter; top 2 bits select digit (bench uses 4)
//  MAX_SHOWN     9999  display clamp; values above it show as 9999
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset
//  score      in   20  current game score, binary, any cycle may change
//  show_high  in   1   1 = display high score, 0 = display current score
//  high       out  20  registered high score
//  seg        out  8   segments, active-low; seg[0]=a..seg[6]=g, seg[7]=dp
//  an         out  4   digit anodes, active-low; an[0]=ones digit
// BEHAVIOUR
//  Reset (rst=0, async): high=0, seg=8'hFF, an=4'hF, scan counter=0,
//   FSM=IDLE, shown-digit register=0.
//  High score: each cycle, if score > high then high <= score (1-cycle latency).
//   Only rst clears high; score dropping (new game) leaves high unchanged.
//  Conversion FSM:
//   IDLE -> LOAD unconditionally.
//   LOAD: sample v = show_high ? high : score; clamp v to MAX_SHOWN.
//    Load 14-bit shift reg and 16-bit BCD reg=0; bit counter=14.
//   SHIFT: per cycle, add 3 to every BCD nibble >=5, then shift left 1.
//    After 14 shifts -> COMMIT.
//   COMMIT: copy BCD to the 4-nibble display register in one cycle -> LOAD.
//   Value change to display latency: at most 2*(1+14+1)=32 cycles.
//   The display register changes only in COMMIT, so no partial or mixed value is
//   ever shown. score/show_high changes mid-conversion affect the next pass only.
//  Scan:
//   REFRESH_BITS-bit counter increments every cycle and wraps.
//   Digit index d = counter[MSB:MSB-1].
//   an and seg are registered together: an = ~(1<<d), seg = code(nibble d).
//   First digit is enabled on the first clk edge after rst deasserts.
//  Encoding (active-low, dp off): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
//   8:80 9:90. Nibbles >9 (illegal) show 8'hBF (dash).
//  Blanking: leading-zero digits above the ones digit show seg=8'hFF with the
//   anode still driven. The ones digit is always shown.
//  dp: when show_high=1, seg[7]=0 on the ones digit only (marks high-score view).
//  Mid-operation reset: all state returns to reset values immediately.
//   Conversion restarts from IDLE after release.
// TESTING (bench: REFRESH_BITS=4, digit period 4 cycles)
//  1. rst=0 -> seg=FF, an=F, high=0. Release, score=0 -> an=1110 seg=C0,
//     an=1101/1011/0111 seg=FF.
//  2. score=1234 held 40 cycles -> scan gives (1110,99) (1101,B0) (1011,A4)
//     (0111,F9).
//  3. score=123456 -> all four digits seg=90 (clamped 9999). high=123456.
//  4. score ramps 0..500, then drops to 7 -> high stays 500.
//     show_high=1 -> digits 5,0,0 with ones seg=40 (dp on), thousands blank.
//  5. score toggles 1111<->2222 every cycle during SHIFT -> every committed frame
//     shows all-1s or all-2s, never a mix.
//  6. Assert rst during SHIFT with high=300 -> high=0, seg=FF, an=F immediately.
//     After release, display shows current score within 32 cycles.

Source files
------------

// File: rtl/score_display.sv
// Score/high-score display stage: tracks the high score, converts the selected
// value to BCD with a sequential double-dabble, and scans a 4-digit 7-seg.
module score_display #(
  parameter int REFRESH_BITS = 17,
  parameter int MAX_SHOWN    = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] score,
  input  logic        show_high,
  output logic [19:0] high,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_e;
  localparam logic [19:0] MAX_V = 20'(MAX_SHOWN);

  state_e                  state_q, state_d;
  logic [19:0]             high_q, high_d;
  logic [13:0]             sh_q, sh_d;
  logic [15:0]             bcd_q, bcd_d, bcd_adj;
  logic [15:0]             disp_q, disp_d;
  logic [3:0]              bits_q, bits_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [7:0]              seg_q, seg_d;
  logic [3:0]              an_q, an_d;
  logic [19:0]             pick, clamped;
  logic [1:0]              dig;
  logic [3:0]              nib;
  logic                    blank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      high_q  <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      bits_q  <= '0;
      disp_q  <= '0;
      scan_q  <= '0;
      seg_q   <= 8'hFF;
      an_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      bits_q  <= bits_d;
      disp_q  <= disp_d;
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (bits_q == 4'd1) state_d = COMMIT;
      COMMIT:  state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    high_d  = (score > high_q) ? score : high_q;
    pick    = show_high ? high_q : score;
    clamped = (pick > MAX_V) ? MAX_V : pick;
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    bits_d = bits_q;
    disp_d = disp_q;
    case (state_q)
      LOAD: begin
        sh_d   = clamped[13:0];
        bcd_d  = '0;
        bits_d = 4'd14;
      end
      SHIFT: begin
        bcd_d  = {bcd_adj[14:0], sh_q[13]};
        sh_d   = {sh_q[12:0], 1'b0};
        bits_d = bits_q - 4'd1;
      end
      // only place the shown value changes, so a half-converted value never shows
      COMMIT:  disp_d = bcd_q;
      default: ;
    endcase
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    dig    = scan_q[REFRESH_BITS-1 -: 2];
    nib    = disp_q[4*dig +: 4];
    case (dig)
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      2'd2:    blank = (disp_q[15:8]  == 8'd0);
      2'd1:    blank = (disp_q[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    case (nib)
      4'd0:    seg_d = 8'hC0;
      4'd1:    seg_d = 8'hF9;
      4'd2:    seg_d = 8'hA4;
      4'd3:    seg_d = 8'hB0;
      4'd4:    seg_d = 8'h99;
      4'd5:    seg_d = 8'h92;
      4'd6:    seg_d = 8'h82;
      4'd7:    seg_d = 8'hF8;
      4'd8:    seg_d = 8'h80;
      4'd9:    seg_d = 8'h90;
      default: seg_d = 8'hBF;
    endcase
    if (blank) seg_d = 8'hFF;
    if (show_high && dig == 2'd0) seg_d[7] = 1'b0;
    an_d = ~(4'd1 << dig);
  end

  assign high = high_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
